// File: rtl/hpdcache_pkg.sv
// Shared types for the hpdcache victim selection logic.
package hpdcache_pkg;

  typedef enum logic [0:0] {
    HPDCACHE_VICTIM_PLRU   = 1'b0,
    HPDCACHE_VICTIM_RROBIN = 1'b1
  } hpdcache_victim_policy_e;

endpackage

// File: rtl/hpdcache_prio_1hot_encoder.sv
// Keeps only the lowest set bit of the input vector (one-hot result, zero if input is zero).
module hpdcache_prio_1hot_encoder #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] val_i,
  output logic [N-1:0] val_o
);

  // Two's complement isolates the least significant set bit.
  assign val_o = val_i & (~val_i + N'(1));

endmodule

// File: rtl/hpdcache_victim_sel.sv
// Victim way selection for a set-associative cache with MRU-bit PLRU or per-set round-robin state.
module hpdcache_victim_sel
  import hpdcache_pkg::*;
#(
  parameter int unsigned             SETS   = 64,
  parameter int unsigned             WAYS   = 8,
  parameter hpdcache_victim_policy_e POLICY = HPDCACHE_VICTIM_PLRU
) (
  input  logic                     clk_i,
  input  logic                     rst_i,

  input  logic                     updt_i,
  input  logic [$clog2(SETS)-1:0]  updt_set_i,
  input  logic [WAYS-1:0]          updt_way_i,

  input  logic                     repl_i,
  input  logic [$clog2(SETS)-1:0]  repl_set_i,
  input  logic [WAYS-1:0]          repl_dir_valid_i,
  input  logic                     repl_updt_i,

  input  logic [WAYS-1:0]          lock_i,

  input  logic                     clr_i,
  input  logic [$clog2(SETS)-1:0]  clr_set_i,

  output logic [WAYS-1:0]          victim_way_o,
  output logic                     victim_valid_o
);

  localparam int unsigned SET_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);

  logic [WAYS-1:0] candidate;
  logic [WAYS-1:0] invalid_ways;
  logic [WAYS-1:0] invalid_way;
  logic [WAYS-1:0] policy_way;
  logic            repl_commit;

  // Marks the given way as recently used; once every unlocked way is marked, restart from it.
  function automatic logic [WAYS-1:0] plru_next(input logic [WAYS-1:0] state,
                                                input logic [WAYS-1:0] way,
                                                input logic [WAYS-1:0] lock);
    logic [WAYS-1:0] next;
    next = state | way;
    if (&(next | lock)) next = way;
    return next;
  endfunction

  assign candidate    = ~lock_i;
  assign invalid_ways = candidate & ~repl_dir_valid_i;

  hpdcache_prio_1hot_encoder #(.N(WAYS)) invalid_enc (
    .val_i (invalid_ways),
    .val_o (invalid_way)
  );

  // Filling an empty way always wins over evicting a valid line.
  assign victim_valid_o = |candidate;
  assign victim_way_o   = (|invalid_ways) ? invalid_way : policy_way;
  assign repl_commit    = repl_i & repl_updt_i & victim_valid_o;

  if (POLICY == HPDCACHE_VICTIM_PLRU) begin : gen_plru
    logic [WAYS-1:0] state_q [SETS];
    logic [WAYS-1:0] free_ways;
    logic [WAYS-1:0] policy_mask;

    assign free_ways   = candidate & ~state_q[repl_set_i];
    assign policy_mask = (|free_ways) ? free_ways : candidate;

    hpdcache_prio_1hot_encoder #(.N(WAYS)) plru_enc (
      .val_i (policy_mask),
      .val_o (policy_way)
    );

    always_ff @(posedge clk_i) begin
      for (int s = 0; s < SETS; s++) begin
        if (rst_i) begin
          state_q[s] <= '0;
        end else if (clr_i && (clr_set_i == SET_W'(s))) begin
          state_q[s] <= '0;
        end else if (repl_commit && (repl_set_i == SET_W'(s))) begin
          state_q[s] <= plru_next(state_q[s], victim_way_o, lock_i);
        end else if (updt_i && (updt_set_i == SET_W'(s))) begin
          state_q[s] <= plru_next(state_q[s], updt_way_i, lock_i);
        end
      end
    end
  end else begin : gen_rrobin
    logic [WAY_W-1:0] ptr_q [SETS];
    logic [WAY_W-1:0] ptr;
    logic [WAYS-1:0]  rot_cand;
    logic [WAYS-1:0]  rot_way;
    logic [WAY_W-1:0] victim_idx;
    logic             unused_updt;

    assign unused_updt = ^{updt_i, updt_set_i, updt_way_i};

    // Rotate so the pointer lands on bit 0, pick the lowest, then rotate back.
    assign ptr      = ptr_q[repl_set_i];
    assign rot_cand = WAYS'({candidate, candidate} >> ptr);

    hpdcache_prio_1hot_encoder #(.N(WAYS)) rr_enc (
      .val_i (rot_cand),
      .val_o (rot_way)
    );

    assign policy_way = WAYS'(({rot_way, rot_way} << ptr) >> WAYS);

    always_comb begin
      victim_idx = '0;
      for (int w = 0; w < WAYS; w++) begin
        if (victim_way_o[w]) victim_idx = WAY_W'(w);
      end
    end

    always_ff @(posedge clk_i) begin
      for (int s = 0; s < SETS; s++) begin
        if (rst_i) begin
          ptr_q[s] <= '0;
        end else if (clr_i && (clr_set_i == SET_W'(s))) begin
          ptr_q[s] <= '0;
        end else if (repl_commit && (repl_set_i == SET_W'(s))) begin
          ptr_q[s] <= victim_idx + WAY_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hpdcache_victim_sel.sv
// Drives a PLRU and a round-robin instance with shared stimulus and compares both against a set-level model.
module tb_hpdcache_victim_sel;
  import hpdcache_pkg::*;

  localparam int SETS = 8;
  localparam int WAYS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       updt;
  logic [2:0] updtSet;
  logic [3:0] updtWay;
  logic       repl;
  logic [2:0] replSet;
  logic [3:0] dirValid;
  logic       replUpdt;
  logic [3:0] lock;
  logic       clr;
  logic [2:0] clrSet;

  logic [3:0] plruWay, rrWay;
  logic       plruValid, rrValid;

  int checkCount = 0;
  int passCount  = 0;

  logic [3:0] plruModel [SETS];
  int         ptrModel  [SETS];

  always #5 clk = ~clk;

  hpdcache_victim_sel #(.SETS(SETS), .WAYS(WAYS), .POLICY(HPDCACHE_VICTIM_PLRU)) dutPlru (
    .clk_i            (clk),
    .rst_i            (rst),
    .updt_i           (updt),
    .updt_set_i       (updtSet),
    .updt_way_i       (updtWay),
    .repl_i           (repl),
    .repl_set_i       (replSet),
    .repl_dir_valid_i (dirValid),
    .repl_updt_i      (replUpdt),
    .lock_i           (lock),
    .clr_i            (clr),
    .clr_set_i        (clrSet),
    .victim_way_o     (plruWay),
    .victim_valid_o   (plruValid)
  );

  hpdcache_victim_sel #(.SETS(SETS), .WAYS(WAYS), .POLICY(HPDCACHE_VICTIM_RROBIN)) dutRr (
    .clk_i            (clk),
    .rst_i            (rst),
    .updt_i           (updt),
    .updt_set_i       (updtSet),
    .updt_way_i       (updtWay),
    .repl_i           (repl),
    .repl_set_i       (replSet),
    .repl_dir_valid_i (dirValid),
    .repl_updt_i      (replUpdt),
    .lock_i           (lock),
    .clr_i            (clr),
    .clr_set_i        (clrSet),
    .victim_way_o     (rrWay),
    .victim_valid_o   (rrValid)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // First way set in mask, scanning upward from start and wrapping.
  function automatic logic [3:0] firstOf(input logic [3:0] mask, input int start);
    int i;
    for (int k = 0; k < WAYS; k++) begin
      i = (start + k) % WAYS;
      if (mask[i]) return 4'b0001 << i;
    end
    return 4'b0000;
  endfunction

  function automatic int indexOf(input logic [3:0] oneHot);
    for (int i = 0; i < WAYS; i++) if (oneHot[i]) return i;
    return 0;
  endfunction

  function automatic logic [3:0] plruNext(input logic [3:0] state, input logic [3:0] way);
    logic [3:0] n;
    n = state | way;
    if ((n | lock) == 4'hF) n = way;
    return n;
  endfunction

  function automatic logic [3:0] expectVictim(input bit roundRobin);
    logic [3:0] cand, invalid, notRecent;
    cand      = ~lock;
    invalid   = cand & ~dirValid;
    notRecent = cand & ~plruModel[replSet];
    if (invalid != 0) return firstOf(invalid, 0);
    if (roundRobin) return firstOf(cand, ptrModel[replSet]);
    if (notRecent != 0) return firstOf(notRecent, 0);
    return firstOf(cand, 0);
  endfunction

  task automatic applyStimulus(input logic updtEn, input logic [2:0] updtS, input logic [3:0] updtW,
                               input logic replEn, input logic [2:0] replS, input logic [3:0] dirV,
                               input logic replU, input logic [3:0] lockM,
                               input logic clrEn, input logic [2:0] clrS);
    updt = updtEn; updtSet = updtS; updtWay = updtW;
    repl = replEn; replSet = replS; dirValid = dirV; replUpdt = replU;
    lock = lockM; clr = clrEn; clrSet = clrS;
    #1;
  endtask

  task automatic probe(input logic [2:0] set, input logic [3:0] lockM);
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0, set, 4'hF, 1'b0, lockM, 1'b0, 3'd0);
  endtask

  // Compare both victims against the model, clock once, then advance the model with the same inputs.
  task automatic stepCycle();
    logic [3:0] expP, expR;
    expP = expectVictim(1'b0);
    expR = expectVictim(1'b1);
    checkOutput("plru_way", plruWay, expP);
    checkOutput("plru_valid", plruValid, lock != 4'hF);
    checkOutput("rr_way", rrWay, expR);
    checkOutput("rr_valid", rrValid, lock != 4'hF);
    @(posedge clk);
    for (int s = 0; s < SETS; s++) begin
      if (rst) begin
        plruModel[s] = 4'h0;
        ptrModel[s]  = 0;
      end else if (clr && clrSet == s) begin
        plruModel[s] = 4'h0;
        ptrModel[s]  = 0;
      end else if (repl && replUpdt && lock != 4'hF && replSet == s) begin
        plruModel[s] = plruNext(plruModel[s], expP);
        ptrModel[s]  = (indexOf(expR) + 1) % WAYS;
      end else if (updt && updtSet == s) begin
        plruModel[s] = plruNext(plruModel[s], updtWay);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int r;
    for (int s = 0; s < SETS; s++) begin
      plruModel[s] = 4'h0;
      ptrModel[s]  = 0;
    end

    rst = 1'b1;
    probe(3'd0, 4'h0);
    stepCycle();
    stepCycle();
    rst = 1'b0;

    probe(3'd0, 4'h0);
    checkOutput("reset_plru_way", plruWay, 4'b0001);
    checkOutput("reset_rr_way", rrWay, 4'b0001);
    checkOutput("reset_valid", plruValid, 1'b1);
    stepCycle();
    probe(3'd4, 4'b0011);
    checkOutput("reset_lock_plru", plruWay, 4'b0100);
    checkOutput("reset_lock_rr", rrWay, 4'b0100);
    stepCycle();

    // MRU bits fill up on set 3 until the last unused way is evicted.
    for (int w = 0; w < 3; w++) begin
      applyStimulus(1'b1, 3'd3, 4'b0001 << w, 1'b0, 3'd0, 4'hF, 1'b0, 4'h0, 1'b0, 3'd0);
      stepCycle();
    end
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b1, 3'd3, 4'hF, 1'b1, 4'h0, 1'b0, 3'd0);
    checkOutput("plru_fill_victim", plruWay, 4'b1000);
    stepCycle();
    probe(3'd3, 4'h0);
    checkOutput("plru_fill_state", plruWay, 4'b0001);
    stepCycle();

    // Set 5 reaches state 0110, then is replaced with way 0 locked.
    applyStimulus(1'b1, 3'd5, 4'b0010, 1'b0, 3'd0, 4'hF, 1'b0, 4'h0, 1'b0, 3'd0);
    stepCycle();
    applyStimulus(1'b1, 3'd5, 4'b0100, 1'b0, 3'd0, 4'hF, 1'b0, 4'h0, 1'b0, 3'd0);
    stepCycle();
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b1, 3'd5, 4'hF, 1'b1, 4'b0001, 1'b0, 3'd0);
    checkOutput("plru_lock_victim", plruWay, 4'b1000);
    stepCycle();
    probe(3'd5, 4'h0);
    checkOutput("plru_lock_state", plruWay, 4'b0001);
    stepCycle();

    // Round-robin pointer of set 6 walks to 3, then wraps past a locked way 3.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 3'd0, 4'd0, 1'b1, 3'd6, 4'hF, 1'b1, 4'h0, 1'b0, 3'd0);
      stepCycle();
    end
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b1, 3'd6, 4'hF, 1'b1, 4'b1000, 1'b0, 3'd0);
    checkOutput("rr_wrap_victim", rrWay, 4'b0001);
    stepCycle();
    probe(3'd6, 4'h0);
    checkOutput("rr_wrap_ptr", rrWay, 4'b0010);
    stepCycle();

    // Same-cycle clr/updt on set 2 with a committed repl on set 7.
    applyStimulus(1'b1, 3'd2, 4'b0001, 1'b0, 3'd0, 4'hF, 1'b0, 4'h0, 1'b0, 3'd0);
    stepCycle();
    applyStimulus(1'b1, 3'd2, 4'b0010, 1'b1, 3'd7, 4'hF, 1'b1, 4'h0, 1'b1, 3'd2);
    stepCycle();
    probe(3'd2, 4'h0);
    checkOutput("clr_plru_set2", plruWay, 4'b0001);
    stepCycle();
    probe(3'd7, 4'h0);
    checkOutput("multi_plru_set7", plruWay, 4'b0010);
    checkOutput("multi_rr_set7", rrWay, 4'b0010);
    stepCycle();

    // Everything locked: no victim and no state change; then an invalid way takes priority.
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b1, 3'd7, 4'hF, 1'b1, 4'hF, 1'b0, 3'd0);
    checkOutput("all_locked_valid", plruValid, 1'b0);
    checkOutput("all_locked_way", plruWay, 4'b0000);
    checkOutput("all_locked_rr_way", rrWay, 4'b0000);
    stepCycle();
    probe(3'd7, 4'h0);
    checkOutput("all_locked_rr_hold", rrWay, 4'b0010);
    stepCycle();
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b1, 3'd7, 4'b1011, 1'b0, 4'h0, 1'b0, 3'd0);
    checkOutput("invalid_plru", plruWay, 4'b0100);
    checkOutput("invalid_rr", rrWay, 4'b0100);
    stepCycle();

    // Reset during a committed replacement clears every set.
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b1, 3'd1, 4'hF, 1'b1, 4'h0, 1'b0, 3'd0);
    stepCycle();
    rst = 1'b1;
    applyStimulus(1'b1, 3'd0, 4'b0001, 1'b1, 3'd1, 4'hF, 1'b1, 4'h0, 1'b0, 3'd0);
    stepCycle();
    rst = 1'b0;
    for (int s = 0; s < SETS; s++) begin
      probe(3'(s), 4'h0);
      checkOutput("rst_plru", plruWay, 4'b0001);
      checkOutput("rst_rr", rrWay, 4'b0001);
      stepCycle();
    end

    // Random traffic with occasional resets, locks and invalid lines.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] lockR, dirR;
      r = $urandom_range(0, 9);
      lockR = (r < 6) ? 4'h0 : (r < 9) ? 4'($urandom) : 4'hF;
      dirR  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      rst   = ($urandom_range(0, 199) == 0);
      applyStimulus(1'($urandom), 3'($urandom), 4'b0001 << $urandom_range(0, 3),
                    1'($urandom), 3'($urandom), dirR, ($urandom_range(0, 3) != 0), lockR,
                    ($urandom_range(0, 6) == 0), 3'($urandom));
      stepCycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/hpdcache_victim_sel.md
HPDCACHE_VICTIM_SEL -- requirements
Module: hpdcache_victim_sel

Interface
REQ-001 SHALL have parameter SETS, default 64, meaning number of cache sets (>=2, power of 2).
REQ-002 SHALL have parameter WAYS, default 8, meaning associativity (>=2, power of 2).
REQ-003 SHALL have parameter POLICY, default HPDCACHE_VICTIM_PLRU, meaning replacement policy: PLRU (MRU-bit pseudo-LRU) or RROBIN (per-set round-robin pointer).
REQ-004 SHALL have clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have updt_i / updt_set_i / updt_way_i  in  1 / log2(SETS) / WAYS  hit-access update, one-hot way.
REQ-007 SHALL have repl_i / repl_set_i / repl_dir_valid_i / repl_updt_i  in  1 / log2(SETS) / WAYS / 1  victim request, valid-line mask, commit-state flag.
REQ-008 SHALL have lock_i  in  WAYS  ways excluded from victim selection, all sets.
REQ-009 SHALL have clr_i / clr_set_i  in  1 / log2(SETS)  clear the state of one set.
REQ-010 SHALL have victim_way_o / victim_valid_o  out  WAYS / 1  one-hot victim and its validity.

Function
REQ-011 SHALL keep per-set state: PLRU = WAYS bits; RROBIN = log2(WAYS)-bit pointer.
REQ-012 SHALL compute victim combinationally from the state of repl_set_i in the same cycle (zero latency).
REQ-013 SHALL define candidate = ~lock_i; victim_valid_o = |candidate; when all ways are locked, victim_way_o = 0 and no state change occurs on repl.
REQ-014 SHALL choose the lowest-index candidate way with repl_dir_valid_i=0 when one exists, for either policy.
REQ-015 PLRU: otherwise SHALL choose the lowest-index candidate way with state bit 0; if none, the lowest-index candidate way.
REQ-016 RROBIN: otherwise SHALL choose the first candidate way at or after the pointer, wrapping modulo WAYS.
REQ-017 PLRU update (updt or committed repl, way W): next = state | W; if (next | lock_i) is all-ones, next = W.
REQ-018 RROBIN: committed repl SHALL set pointer = index(victim)+1 mod WAYS; updt_i SHALL leave state unchanged.
REQ-019 Repl SHALL commit state only when repl_i & repl_updt_i & victim_valid_o.
REQ-020 clr_i SHALL set the state of clr_set_i to 0.
REQ-021 Simultaneous operations on different sets SHALL all take effect in the same cycle.
REQ-022 Same-set priority SHALL be clr > repl > updt; a lower-priority operation is dropped entirely.
REQ-023 SHALL not change state in cycles with no updt_i, repl_i or clr_i asserted.

Reset
REQ-024 On rst_i high at a clock edge, all set state SHALL become 0, overriding any concurrent operation.
REQ-025 After reset, victim_way_o SHALL be the lowest-index candidate way (way 0 with lock_i=0) and victim_valid_o = |~lock_i.

Structure
REQ-026 The policy enum (HPDCACHE_VICTIM_PLRU, HPDCACHE_VICTIM_RROBIN) SHALL be defined in hpdcache_pkg.
REQ-027 Lowest-index selection SHALL reuse hpdcache_prio_1hot_encoder; RROBIN SHALL rotate by the pointer, encode, and rotate back.
REQ-028 Only the state array for the selected POLICY SHALL be generated.

Verification
REQ-029 PLRU, WAYS=4, set 3, all valid: updt ways 0,1,2 then repl commit -> victim 0b1000, state of set 3 = 0b1000.
REQ-030 PLRU, lock_i=0b0001, set 5 state 0b0110, all valid: repl -> victim 0b1000 (unlocked ways all MRU) -> state 0b1000.
REQ-031 RROBIN, WAYS=4, pointer 3, lock_i=0b1000, all valid: repl -> victim 0b0001, pointer 1.
REQ-032 Same cycle: updt set 2 way 1, repl set 7 commit, clr set 2 -> set 2 state 0, set 7 updated.
REQ-033 lock_i all-ones, repl commit -> victim_valid_o=0, victim_way_o=0, no state change; repl_dir_valid_i=0b1011 with lock_i=0 -> victim 0b0100.
REQ-034 rst_i asserted during repl commit -> all sets read state 0 on the following cycle.
